// File: rtl/cache_dre_ctrl.sv
// Maintenance controller for the cache byte-readable (dre) RAM.
// Drives the ri-side port and the sel mux input of cache_rw_dre to run
// read-modify-write set/clear of one row/channel entry, or a full
// invalidate sweep of every row and channel.
module cache_dre_ctrl #(
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [ADDR_WIDTH-2:0] cmd_row,
   input  logic [1:0]            cmd_channel,
   input  logic [7:0]            cmd_mask,
   output logic                  done,
   output logic                  sel,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] ri_readAddress,
   output logic [1:0]            ri_readChannel,
   input  logic [7:0]            ri_readData,
   output logic [ADDR_WIDTH-1:0] ri_writeAddress,
   output logic [1:0]            ri_writeChannel,
   output logic                  ri_writeEnable,
   output logic [7:0]            ri_writeData
);

   localparam logic [1:0] OP_SET    = 2'd0;
   localparam logic [1:0] OP_CLR    = 2'd1;
   localparam logic [1:0] OP_CLRALL = 2'd2;
   localparam logic [1:0] OP_NOP    = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RD    = 2'd1,
      S_WR    = 2'd2,
      S_SWEEP = 2'd3
   } state_t;

   state_t                state_reg, state_next;
   logic                  done_reg, done_next;
   logic [1:0]            op_reg;
   logic [ADDR_WIDTH-2:0] row_reg;
   logic [1:0]            channel_reg;
   logic [7:0]            mask_reg;
   // Sweep counter: {row, channel}, channel in the low two bits so it steps fastest
   logic [ADDR_WIDTH:0]   cnt_reg;
   logic                  accept;

   assign accept = cmd_valid && (state_reg == S_IDLE);

   // State, command latch, sweep counter and completion pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         done_reg    <= 1'b0;
         op_reg      <= OP_NOP;
         row_reg     <= '0;
         channel_reg <= '0;
         mask_reg    <= '0;
         cnt_reg     <= '0;
      end else begin
         state_reg <= state_next;
         done_reg  <= done_next;
         if (accept) begin
            op_reg      <= cmd_op;
            row_reg     <= cmd_row;
            channel_reg <= cmd_channel;
            mask_reg    <= cmd_mask;
            cnt_reg     <= '0;
         end else if (state_reg == S_SWEEP) begin
            cnt_reg <= cnt_reg + {{ADDR_WIDTH{1'b0}}, 1'b1};
         end
      end
   end

   // Next-state decode; done is raised for the cycle after the final action
   always_comb begin
      state_next = state_reg;
      done_next  = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_SET, OP_CLR: state_next = S_RD;
                  OP_CLRALL:      state_next = S_SWEEP;
                  default:        done_next  = 1'b1;
               endcase
            end
         end
         S_RD: state_next = S_WR;
         S_WR: begin
            state_next = S_IDLE;
            done_next  = 1'b1;
         end
         S_SWEEP: begin
            if (&cnt_reg) begin
               state_next = S_IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // ri-side port drive; everything is zero while idle so the RAM sees no traffic
   always_comb begin
      ri_readAddress  = '0;
      ri_readChannel  = '0;
      ri_writeAddress = '0;
      ri_writeChannel = '0;
      ri_writeEnable  = 1'b0;
      ri_writeData    = '0;
      case (state_reg)
         S_RD: begin
            ri_readAddress = {row_reg, 1'b0};
            ri_readChannel = channel_reg;
         end
         S_WR: begin
            // Read data is muxed on the current channel, so keep driving it
            ri_readChannel  = channel_reg;
            ri_writeAddress = {row_reg, 1'b0};
            ri_writeChannel = channel_reg;
            ri_writeEnable  = 1'b1;
            ri_writeData    = (op_reg == OP_CLR) ? (ri_readData & ~mask_reg)
                                                 : (ri_readData | mask_reg);
         end
         S_SWEEP: begin
            ri_writeAddress = {cnt_reg[ADDR_WIDTH:2], 1'b0};
            ri_writeChannel = cnt_reg[1:0];
            ri_writeEnable  = 1'b1;
            ri_writeData    = 8'h00;
         end
         default: ;
      endcase
   end

   assign cmd_ready = (state_reg == S_IDLE);
   assign sel       = (state_reg != S_IDLE);
   assign busy      = sel;
   assign done      = done_reg;

endmodule

// File: tb/tb_cache_dre_ctrl.sv
// Testbench for cache_dre_ctrl: a behavioural dre RAM sits on the ri port,
// and a command-level reference model predicts the contents of every entry.
module tb_cache_dre_ctrl;

   localparam int AW        = 9;
   localparam int ROWS      = 1 << (AW - 1);
   localparam int ENTRIES   = ROWS * 4;
   localparam int SWEEP_LEN = 1 << (AW + 1);

   localparam logic [1:0] OP_SET    = 2'd0;
   localparam logic [1:0] OP_CLR    = 2'd1;
   localparam logic [1:0] OP_CLRALL = 2'd2;
   localparam logic [1:0] OP_NOP    = 2'd3;

   logic          clk;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-2:0] cmd_row;
   logic [1:0]    cmd_channel;
   logic [7:0]    cmd_mask;
   logic          done;
   logic          sel;
   logic          busy;
   logic [AW-1:0] ri_readAddress;
   logic [1:0]    ri_readChannel;
   logic [7:0]    ri_readData;
   logic [AW-1:0] ri_writeAddress;
   logic [1:0]    ri_writeChannel;
   logic          ri_writeEnable;
   logic [7:0]    ri_writeData;

   int vectors = 0;
   int miscompares = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   cache_dre_ctrl #(.ADDR_WIDTH(AW)) dut (
      .clk             (clk),
      .rst             (rst),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_op          (cmd_op),
      .cmd_row         (cmd_row),
      .cmd_channel     (cmd_channel),
      .cmd_mask        (cmd_mask),
      .done            (done),
      .sel             (sel),
      .busy            (busy),
      .ri_readAddress  (ri_readAddress),
      .ri_readChannel  (ri_readChannel),
      .ri_readData     (ri_readData),
      .ri_writeAddress (ri_writeAddress),
      .ri_writeChannel (ri_writeChannel),
      .ri_writeEnable  (ri_writeEnable),
      .ri_writeData    (ri_writeData)
   );

   // Behavioural dre RAM: row address registered, channel muxed on the current channel
   logic [7:0]    mem [ENTRIES];
   logic [AW-2:0] rd_row;
   int            wr_count = 0;

   always @(posedge clk) begin
      rd_row <= ri_readAddress[AW-1:1];
      if (ri_writeEnable === 1'b1) begin
         mem[{ri_writeAddress[AW-1:1], ri_writeChannel}] <= ri_writeData;
         wr_count <= wr_count + 1;
      end
   end

   assign ri_readData = mem[{rd_row, ri_readChannel}];

   // Reference contents, indexed row*4 + channel
   logic [7:0] ref_mem [ENTRIES];

   // Issue one command from a negedge with the DUT idle; return at the negedge where done is seen.
   // Observes per-cycle behaviour and reports latency, write count and number of bad cycles.
   task automatic run_cmd(input logic [1:0] op, input int row, input int ch, input logic [7:0] mask,
                          input bit toggle, output int lat, output int writes, output int bad);
      int         idx;
      logic [7:0] exp_wd;
      idx    = row * 4 + ch;
      exp_wd = (op == OP_SET) ? (ref_mem[idx] | mask) : (ref_mem[idx] & ~mask);
      cmd_valid   = 1'b1;
      cmd_op      = op;
      cmd_row     = (AW-1)'(row);
      cmd_channel = 2'(ch);
      cmd_mask    = mask;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1;
      writes = 0;
      bad = 0;
      while (done !== 1'b1 && lat < SWEEP_LEN + 16) begin
         if (cmd_ready !== 1'b0 || sel !== 1'b1 || busy !== 1'b1) bad++;
         if (ri_writeEnable === 1'b1) begin
            if (op == OP_CLRALL) begin
               if (ri_writeData !== 8'h00 || ri_writeAddress !== AW'((writes / 4) * 2) ||
                   ri_writeChannel !== 2'(writes % 4)) bad++;
            end else begin
               if (ri_writeData !== exp_wd || ri_writeAddress !== AW'(row * 2) ||
                   ri_writeChannel !== 2'(ch) || ri_readChannel !== 2'(ch)) bad++;
            end
            writes++;
         end
         if (toggle) begin
            cmd_valid   = 1'($urandom_range(0, 1));
            cmd_op      = 2'($urandom);
            cmd_row     = (AW-1)'($urandom);
            cmd_channel = 2'($urandom);
            cmd_mask    = 8'($urandom);
         end
         @(negedge clk);
         lat++;
      end
      cmd_valid = 1'b0;
      if (op == OP_SET || op == OP_CLR) ref_mem[idx] = exp_wd;
      if (op == OP_CLRALL) for (int i = 0; i < ENTRIES; i++) ref_mem[i] = 8'h00;
   endtask

   // Whole-RAM comparison against the reference model
   task automatic check_mem(input string name);
      int bad_cnt;
      int first;
      bad_cnt = 0;
      first = -1;
      for (int i = 0; i < ENTRIES; i++) begin
         if (mem[i] !== ref_mem[i]) begin
            if (first < 0) first = i;
            bad_cnt++;
         end
      end
      vectors++;
      if (bad_cnt != 0) begin
         miscompares++;
         $display("FAIL %s: %0d entries differ, first idx %0d got %h want %h",
                  name, bad_cnt, first, mem[first], ref_mem[first]);
      end
   endtask

   task automatic check_cmd(input string name, input int lat, input int exp_lat,
                            input int writes, input int exp_writes, input int bad);
      vectors++;
      if (lat !== exp_lat) begin
         miscompares++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      vectors++;
      if (writes !== exp_writes) begin
         miscompares++;
         $display("FAIL %s writes: got %0d want %0d", name, writes, exp_writes);
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL %s per-cycle: got %0d bad cycles want 0", name, bad);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cmd_valid = 1'b1;
      cmd_op = OP_SET;
      cmd_row = 5;
      cmd_channel = 1;
      cmd_mask = 8'hFF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({sel, busy, cmd_ready, done, ri_writeEnable} !== 5'b00100) begin
         miscompares++;
         $display("FAIL reset_flags: got sel/busy/ready/done/we=%b want 00100",
                  {sel, busy, cmd_ready, done, ri_writeEnable});
      end
      vectors++;
      if (ri_readAddress !== '0 || ri_writeAddress !== '0 || ri_writeData !== '0 ||
          ri_readChannel !== '0 || ri_writeChannel !== '0) begin
         miscompares++;
         $display("FAIL reset_ri: got ra=%h wa=%h wd=%h want 0", ri_readAddress,
                  ri_writeAddress, ri_writeData);
      end
      cmd_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (sel !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_no_accept: got sel=%b done=%b want 0 0", sel, done);
      end
   endtask

   task automatic test_clrall();
      int lat, writes, bad;
      run_cmd(OP_CLRALL, 0, 0, 8'h00, 1'b0, lat, writes, bad);
      $display("clrall: latency %0d writes %0d", lat, writes);
      check_cmd("clrall", lat, SWEEP_LEN + 1, writes, SWEEP_LEN, bad);
      check_mem("clrall_mem");
   endtask

   task automatic test_set();
      int lat, writes, bad;
      run_cmd(OP_SET, 5, 2, 8'h0F, 1'b0, lat, writes, bad);
      $display("set row 5 ch 2 mask 0f: latency %0d entry %h", lat, mem[5*4+2]);
      check_cmd("set", lat, 3, writes, 1, bad);
      vectors++;
      if (mem[5*4+2][3:0] !== 4'hF || mem[5*4+2][7:4] !== 4'h0) begin
         miscompares++;
         $display("FAIL set_halves: got %h want 0f", mem[5*4+2]);
      end
   endtask

   task automatic test_back_to_back();
      int lat, writes, bad;
      run_cmd(OP_SET, 5, 2, 8'hFF, 1'b0, lat, writes, bad);
      run_cmd(OP_CLR, 5, 2, 8'h05, 1'b0, lat, writes, bad);
      $display("clr mask 05: latency %0d entry %h", lat, mem[5*4+2]);
      check_cmd("clr", lat, 3, writes, 1, bad);
      vectors++;
      if (mem[5*4+2] !== 8'hFA) begin
         miscompares++;
         $display("FAIL clr_entry: got %h want fa", mem[5*4+2]);
      end
      vectors++;
      if (done !== 1'b1 || cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_ready: got done=%b ready=%b want 1 1", done, cmd_ready);
      end
      run_cmd(OP_SET, 5, 2, 8'h01, 1'b0, lat, writes, bad);
      $display("b2b set mask 01: latency %0d entry %h", lat, mem[5*4+2]);
      check_cmd("b2b_set", lat, 3, writes, 1, bad);
      vectors++;
      if (mem[5*4+2] !== 8'hFB) begin
         miscompares++;
         $display("FAIL b2b_entry: got %h want fb", mem[5*4+2]);
      end
   endtask

   task automatic test_sweep_ignore();
      int lat, writes, bad;
      run_cmd(OP_CLRALL, 0, 0, 8'h00, 1'b1, lat, writes, bad);
      $display("clrall with cmd_valid toggling: latency %0d writes %0d", lat, writes);
      check_cmd("sweep_ignore", lat, SWEEP_LEN + 1, writes, SWEEP_LEN, bad);
      check_mem("sweep_ignore_mem");
   endtask

   task automatic test_random();
      int lat, writes, bad, row, ch, gap, sel_op;
      logic [1:0] op;
      logic [7:0] mask;
      for (int n = 0; n < 60; n++) begin
         sel_op = $urandom_range(0, 19);
         op   = (sel_op < 10) ? OP_SET : (sel_op < 17) ? OP_CLR : OP_NOP;
         row  = $urandom_range(0, ROWS - 1);
         ch   = $urandom_range(0, 3);
         mask = 8'($urandom);
         gap  = $urandom_range(0, 2);
         repeat (gap) @(negedge clk);
         run_cmd(op, row, ch, mask, 1'b0, lat, writes, bad);
         $display("rand %0d: op %0d row %0d ch %0d mask %h gap %0d latency %0d entry %h",
                  n, op, row, ch, mask, gap, lat, mem[row*4+ch]);
         check_cmd("random", lat, (op == OP_NOP) ? 1 : 3, writes, (op == OP_NOP) ? 0 : 1, bad);
      end
      check_mem("random_mem");
   endtask

   task automatic test_reset_mid_sweep();
      int w0;
      w0 = wr_count;
      cmd_valid = 1'b1;
      cmd_op = OP_CLRALL;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (300) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if (sel !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_state: got sel=%b done=%b ready=%b want 0 0 1", sel, done, cmd_ready);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || sel !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_no_done: got done=%b sel=%b want 0 0", done, sel);
      end
      vectors++;
      if (wr_count - w0 !== 301) begin
         miscompares++;
         $display("FAIL abort_writes: got %0d want 301", wr_count - w0);
      end
      $display("sweep aborted after %0d writes", wr_count - w0);
      for (int i = 0; i <= 300; i++) ref_mem[i] = 8'h00;
      check_mem("abort_mem");
   endtask

   task automatic test_nop();
      int lat, writes, bad, w0;
      w0 = wr_count;
      run_cmd(OP_NOP, 7, 1, 8'hFF, 1'b0, lat, writes, bad);
      $display("nop: latency %0d", lat);
      check_cmd("nop", lat, 1, writes, 0, bad);
      @(negedge clk);
      vectors++;
      if (done !== 1'b0) begin
         miscompares++;
         $display("FAIL nop_pulse: got done=%b want 0", done);
      end
      vectors++;
      if (wr_count !== w0) begin
         miscompares++;
         $display("FAIL nop_write: got %0d writes want 0", wr_count - w0);
      end
      check_mem("nop_mem");
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_op = OP_NOP;
      cmd_row = '0;
      cmd_channel = '0;
      cmd_mask = '0;
      @(negedge clk);
      test_reset();
      test_clrall();
      test_set();
      test_back_to_back();
      test_sweep_ignore();
      test_random();
      test_reset_mid_sweep();
      test_nop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
